// File: rtl/hyperbus_target.sv
// HyperBus target model: decodes the 48-bit CA, applies a fixed initial latency and
// serves linear bursts from an internal word memory plus a small ID/config register space.
module hyperbus_target #(
    parameter int          MEM_WORDS = 256,
    parameter int          LAT_BYTES = 12,
    parameter logic [15:0] ID_WORD   = 16'h0C81,
    parameter logic [15:0] CFG_RESET = 16'h8F1F
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs_n,
    input  logic [7:0]  dq_in,
    input  logic        rwds_in,
    output logic [7:0]  dq_out,
    output logic        dq_oe,
    output logic        rwds_out,
    output logic        rwds_oe,
    output logic [15:0] cfg_reg,
    output logic        busy
);

    localparam int AW = $clog2(MEM_WORDS);

    typedef enum logic [2:0] {IDLE, CA, LAT, RD, WR, WAIT_CS} state_t;

    state_t         state;
    logic [38:0]    ca_sr;
    logic [7:0]     cnt;
    logic [AW-1:0]  addr;
    logic           is_read;
    logic           is_reg;
    logic           lo;
    logic           reg_done;
    logic [7:0]     cfg_hold;
    logic [15:0]    mem [MEM_WORDS];
    logic [15:0]    rd_word;
    logic           we_hi;
    logic           we_lo;

    always_comb begin
        rd_word = mem[addr];
        if (is_reg) begin
            rd_word = addr[0] ? cfg_reg : ID_WORD;
        end
    end

    // Memory bytes commit in the cycle they are sampled, so an aborted word keeps its high byte.
    always_comb begin
        we_hi = !rst && !cs_n && (state == WR) && !is_reg && !lo && !rwds_in;
        we_lo = !rst && !cs_n && (state == WR) && !is_reg &&  lo && !rwds_in;
    end

    always_ff @(posedge clk) begin
        if (we_hi) mem[addr][15:8] <= dq_in;
        if (we_lo) mem[addr][7:0]  <= dq_in;
    end

    // ca_sr holds {R/W#, space, CA[44:8]}; CA[45] is not needed for linear bursts.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= cs_n ? IDLE : WAIT_CS;
            dq_out   <= '0;
            dq_oe    <= 1'b0;
            rwds_out <= 1'b0;
            rwds_oe  <= 1'b0;
            busy     <= 1'b0;
            cfg_reg  <= CFG_RESET;
        end else if (cs_n) begin
            state    <= IDLE;
            dq_out   <= '0;
            dq_oe    <= 1'b0;
            rwds_out <= 1'b0;
            rwds_oe  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ca_sr    <= {dq_in[7:6], 32'd0, dq_in[4:0]};
                    cnt      <= 8'd1;
                    busy     <= 1'b1;
                    rwds_oe  <= 1'b1;
                    rwds_out <= 1'b0;
                    state    <= CA;
                end
                CA: begin
                    ca_sr[36:0] <= {ca_sr[28:0], dq_in};
                    cnt         <= cnt + 8'd1;
                    if (cnt == 8'd5) begin
                        is_read  <= ca_sr[38];
                        is_reg   <= ca_sr[37];
                        addr     <= AW'({ca_sr[36:8], dq_in[2:0]});
                        rwds_oe  <= 1'b0;
                        cnt      <= 8'd0;
                        lo       <= 1'b0;
                        reg_done <= 1'b0;
                        state    <= (!ca_sr[38] && ca_sr[37]) ? WR : LAT;
                    end
                end
                LAT: begin
                    // The first read byte is launched on the last latency edge.
                    if (cnt == 8'(LAT_BYTES - 1)) begin
                        if (is_read) begin
                            dq_out   <= rd_word[15:8];
                            dq_oe    <= 1'b1;
                            rwds_oe  <= 1'b1;
                            rwds_out <= 1'b1;
                            lo       <= 1'b1;
                            state    <= RD;
                        end else begin
                            state <= WR;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                RD: begin
                    if (lo) begin
                        dq_out   <= rd_word[7:0];
                        rwds_out <= 1'b0;
                        addr     <= addr + AW'(1);
                        lo       <= 1'b0;
                    end else begin
                        dq_out   <= rd_word[15:8];
                        rwds_out <= 1'b1;
                        lo       <= 1'b1;
                    end
                end
                WR: begin
                    if (is_reg) begin
                        if (!reg_done) begin
                            if (!lo) begin
                                cfg_hold <= dq_in;
                                lo       <= 1'b1;
                            end else begin
                                cfg_reg  <= {cfg_hold, dq_in};
                                reg_done <= 1'b1;
                            end
                        end
                    end else begin
                        lo <= !lo;
                        if (lo) addr <= addr + AW'(1);
                    end
                end
                WAIT_CS: state <= WAIT_CS;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hyperbus_target.sv
// Directed bench for hyperbus_target: inputs change and outputs are checked on the falling
// edge, so each check sees the registered outputs of the current bus byte slot.
module tb_hyperbus_target;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs_n;
    logic [7:0]  dq_in;
    logic        rwds_in;
    logic [7:0]  dq_out;
    logic        dq_oe;
    logic        rwds_out;
    logic        rwds_oe;
    logic [15:0] cfg_reg;
    logic        busy;

    int testsRun = 0;
    int testsFailed = 0;

    hyperbus_target dut (
        .clk(clk), .rst(rst), .cs_n(cs_n), .dq_in(dq_in), .rwds_in(rwds_in),
        .dq_out(dq_out), .dq_oe(dq_oe), .rwds_out(rwds_out), .rwds_oe(rwds_oe),
        .cfg_reg(cfg_reg), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic csn, input logic [7:0] d, input logic m);
        @(negedge clk);
        cs_n    = csn;
        dq_in   = d;
        rwds_in = m;
    endtask

    task automatic startTx(input logic rw, input logic sp, input logic [31:0] waddr);
        logic [47:0] ca;
        ca = '0;
        ca[47] = rw;
        ca[46] = sp;
        ca[44:16] = waddr[31:3];
        ca[2:0] = waddr[2:0];
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, ca[47-8*i -: 8], 1'b0);
            if (i > 0) begin
                checkOutput("ca_phase", {12'd0, rwds_oe, rwds_out, dq_oe, busy}, 16'b1001);
            end
        end
    endtask

    task automatic latency();
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0);
            checkOutput("lat_oe", {14'd0, dq_oe, rwds_oe}, 16'd0);
        end
    endtask

    task automatic wrByte(input logic [7:0] d, input logic m);
        applyStimulus(1'b0, d, m);
        checkOutput("wr_oe", {14'd0, dq_oe, rwds_oe}, 16'd0);
    endtask

    task automatic rdByte(input string tag, input logic [7:0] expByte, input logic expRwds);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput(tag, {5'd0, dq_oe, rwds_oe, rwds_out, dq_out}, {5'd0, 1'b1, 1'b1, expRwds, expByte});
    endtask

    task automatic endTx();
        applyStimulus(1'b1, 8'h00, 1'b0);
        applyStimulus(1'b1, 8'h00, 1'b0);
        checkOutput("end_idle", {13'd0, dq_oe, rwds_oe, busy}, 16'd0);
    endtask

    task automatic memWrite(input logic [31:0] waddr, input logic [15:0] w);
        startTx(1'b0, 1'b0, waddr);
        latency();
        wrByte(w[15:8], 1'b0);
        wrByte(w[7:0], 1'b0);
        endTx();
    endtask

    task automatic readWord(input string tag, input logic [31:0] waddr, input logic [15:0] w);
        startTx(1'b1, 1'b0, waddr);
        latency();
        rdByte(tag, w[15:8], 1'b1);
        rdByte(tag, w[7:0], 1'b0);
        endTx();
    endtask

    initial begin
        rst = 1'b1;
        cs_n = 1'b1;
        dq_in = 8'h00;
        rwds_in = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_outs", {dq_out, 4'd0, dq_oe, rwds_oe, rwds_out, busy}, 16'd0);
        checkOutput("rst_cfg", cfg_reg, 16'h8F1F);

        // Burst write then read back with exact first-byte timing at n=18.
        startTx(1'b0, 1'b0, 32'h10);
        latency();
        wrByte(8'hAB, 1'b0);
        wrByte(8'hCD, 1'b0);
        wrByte(8'h12, 1'b0);
        wrByte(8'h34, 1'b0);
        endTx();
        startTx(1'b1, 1'b0, 32'h10);
        latency();
        rdByte("rd_b0", 8'hAB, 1'b1);
        rdByte("rd_b1", 8'hCD, 1'b0);
        rdByte("rd_b2", 8'h12, 1'b1);
        rdByte("rd_b3", 8'h34, 1'b0);
        endTx();

        // Masked high byte keeps its old value.
        memWrite(32'd5, 16'hFFFF);
        startTx(1'b0, 1'b0, 32'd5);
        latency();
        wrByte(8'h00, 1'b1);
        wrByte(8'h00, 1'b0);
        endTx();
        readWord("mask", 32'd5, 16'hFF00);

        // Address wrap on write and read.
        startTx(1'b0, 1'b0, 32'd254);
        latency();
        wrByte(8'h11, 1'b0); wrByte(8'h11, 1'b0);
        wrByte(8'h22, 1'b0); wrByte(8'h22, 1'b0);
        wrByte(8'h33, 1'b0); wrByte(8'h33, 1'b0);
        endTx();
        startTx(1'b1, 1'b0, 32'd254);
        latency();
        rdByte("wrap_254h", 8'h11, 1'b1); rdByte("wrap_254l", 8'h11, 1'b0);
        rdByte("wrap_255h", 8'h22, 1'b1); rdByte("wrap_255l", 8'h22, 1'b0);
        rdByte("wrap_0h", 8'h33, 1'b1);   rdByte("wrap_0l", 8'h33, 1'b0);
        endTx();
        readWord("wrap_addr0", 32'd0, 16'h3333);

        // Zero-latency register write; cfg_reg changes only after the second byte.
        startTx(1'b0, 1'b1, 32'd0);
        wrByte(8'h8E, 1'b0);
        checkOutput("cfg_hold_n6", cfg_reg, 16'h8F1F);
        wrByte(8'h17, 1'b1);
        checkOutput("cfg_hold_n7", cfg_reg, 16'h8F1F);
        wrByte(8'h55, 1'b0);
        checkOutput("cfg_after_n7", cfg_reg, 16'h8E17);
        wrByte(8'hAA, 1'b0);
        endTx();
        checkOutput("cfg_ignore_extra", cfg_reg, 16'h8E17);
        startTx(1'b1, 1'b1, 32'd0);
        latency();
        rdByte("reg_id_h", 8'h0C, 1'b1);
        rdByte("reg_id_l", 8'h81, 1'b0);
        rdByte("reg_cfg_h", 8'h8E, 1'b1);
        rdByte("reg_cfg_l", 8'h17, 1'b0);
        endTx();

        // Abort after the high byte of a write word.
        memWrite(32'h20, 16'h5555);
        startTx(1'b0, 1'b0, 32'h20);
        latency();
        wrByte(8'hA0, 1'b0);
        endTx();
        readWord("abort", 32'h20, 16'hA055);

        // Reset in the middle of a read burst.
        startTx(1'b1, 1'b0, 32'h10);
        latency();
        rdByte("pre_rst_h", 8'hAB, 1'b1);
        rdByte("pre_rst_l", 8'hCD, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_mid_outs", {dq_out, 4'd0, dq_oe, rwds_oe, rwds_out, busy}, 16'd0);
        checkOutput("rst_mid_cfg", cfg_reg, 16'h8F1F);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 8'hA5, 1'b0);
            checkOutput("wait_cs_quiet", {13'd0, dq_oe, rwds_oe, busy}, 16'd0);
        end
        endTx();
        readWord("post_rst", 32'h10, 16'hABCD);
        readWord("post_rst2", 32'h11, 16'h1234);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
